// File: rtl/rv32i_pkg.sv
// rv32i_pkg: funct3 access-size codes, responder FSM states, illegal-f3 helper
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores only exist as sb/sh/sw; loads have no encodings 011/110/111.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
//   f3       in  3   access size/sign (funct3)
//   addr     in  2   low byte-address bits
//   wdata    in  32  store data, low bytes used for sb/sh
//   raw      in  32  word currently held in the addressed memory slot
//   be       out 4   byte enables for the store
//   sdata    out 32  store data replicated onto every candidate lane
//   ldata    out 32  load data, sign- or zero-extended
//   misalign out 1   halfword on odd address or word on non-word address
module mem_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb       = raw[{addr, 3'b000} +: 8];
        lh       = addr[1] ? raw[31:16] : raw[15:0];
        misalign = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr != 2'b00);
        // Replicating the data means the enable mask alone selects the lane.
        be       = f3[1:0] == 2'b00 ? 4'b0001 << addr :
                   f3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        sdata    = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                   f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        ldata    = f3 == F3_B  ? {{24{lb[7]}}, lb} :
                   f3 == F3_H  ? {{16{lh[15]}}, lh} :
                   f3 == F3_W  ? raw :
                   f3 == F3_BU ? {24'd0, lb} :
                   f3 == F3_HU ? {16'd0, lh} : 32'd0;
    end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: fixed-latency load/store data memory with one-cycle ready pulse
//   clk   in  1   system clock, rising edge
//   reset in  1   asynchronous active-high reset (memory contents kept)
//   req   in  1   request valid, accepted only in IDLE
//   we    in  1   1 = store, 0 = load
//   addr  in  32  byte address, wraps modulo memory size
//   wdata in  32  store data
//   f3    in  3   funct3 access size
//   ready out 1   one-cycle response pulse
//   rdata out 32  load data, held until the next response
//   err   out 1   misaligned access or illegal f3, valid with ready
module data_mem_resp
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         f3_q, f3_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               idle, enter;
    logic               s_we;
    logic [ADDR_W+1:0]  s_addr;
    logic [31:0]        s_wdata, raw, sdata, ldata;
    logic [2:0]         s_f3;
    logic [3:0]         be;
    logic               misalign, acc_err, wen;
    logic               unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    // With LATENCY=1 the access edge is the accept edge, so the live inputs
    // are used in IDLE; otherwise the latched copy drives the access.
    assign idle    = state_q == IDLE;
    assign s_we    = idle ? we : we_q;
    assign s_addr  = idle ? addr[ADDR_W+1:0] : addr_q;
    assign s_wdata = idle ? wdata : wdata_q;
    assign s_f3    = idle ? f3 : f3_q;
    assign raw     = mem[s_addr[ADDR_W+1:2]];

    mem_lane_align u_align (
        .f3       (s_f3),
        .addr     (s_addr[1:0]),
        .wdata    (s_wdata),
        .raw      (raw),
        .be       (be),
        .sdata    (sdata),
        .ldata    (ldata),
        .misalign (misalign)
    );

    assign acc_err = misalign | f3_illegal(s_we, s_f3);
    assign wen     = enter & s_we & ~acc_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        enter   = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                addr_d  = addr[ADDR_W+1:0];
                wdata_d = wdata;
                f3_d    = f3;
                cnt_d   = CNT_INIT;
                enter   = LATENCY == 1;
                state_d = LATENCY == 1 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    enter   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = enter;
        err_d   = enter & acc_err;
        rdata_d = enter ? ((acc_err || s_we) ? 32'd0 : ldata) : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is never reset; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (wen && !reset)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[s_addr[ADDR_W+1:2]][8*i +: 8] <= sdata[8*i +: 8];
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for data_mem_resp at LATENCY 2, plus LATENCY 1 and 4 timing checks
module tb_data_mem_resp;
    import rv32i_pkg::*;

    logic clk = 1'b0, reset = 1'b1;
    logic req = 1'b0, we = 1'b0, ready, err;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic [2:0] f3 = 3'd0;

    logic req1 = 1'b0, we1 = 1'b0, ready1, err1;
    logic [31:0] addr1 = 32'd0, wdata1 = 32'd0, rdata1;
    logic [2:0] f31 = 3'd0;

    logic req4 = 1'b0, we4 = 1'b0, ready4, err4;
    logic [31:0] addr4 = 32'd0, wdata4 = 32'd0, rdata4;
    logic [2:0] f34 = 3'd0;

    int cyc = 0, vectors = 0, miscomp = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        bit          chk;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .f3(f3), .ready(ready), .rdata(rdata), .err(err));
    data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .f3(f31), .ready(ready1), .rdata(rdata1), .err(err1));
    data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
        .f3(f34), .ready(ready4), .rdata(rdata4), .err(err4));

    // Monitor: every ready pulse pops one expectation (err, data, arrival cycle).
    always @(negedge clk) begin
        if (ready) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscomp++;
                $display("FAIL unexpected_ready: got ready=1 err=%0b rdata=%h at cycle %0d, expected no response", err, rdata, cyc);
            end else begin
                mx = sbq.pop_front();
                if (err !== mx.err || (mx.chk && rdata !== mx.rd) || cyc != mx.cyc) begin
                    miscomp++;
                    $display("FAIL resp: got err=%0b rdata=%h cycle=%0d, expected err=%0b rdata=%h cycle=%0d",
                             err, rdata, cyc, mx.err, mx.rd, mx.cyc);
                end
            end
        end else if (err !== 1'b0) begin
            miscomp++;
            $display("FAIL err_without_ready: got err=%b, expected 0 at cycle %0d", err, cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 DUT; ready is due 2 cycles after the drive cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          input logic e, input logic [31:0] r, input bit chk);
        exp_t x;
        bit seen;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; f3 = f;
        x.err = e; x.rd = r; x.chk = chk; x.cyc = cyc + 2;
        sbq.push_back(x);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = ready;
        end
        if (!seen) begin
            vectors++;
            miscomp++;
            $display("FAIL timeout: no ready for addr=%h, expected within 30 cycles", a);
        end
        req = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b0;

        do_req(1, 32'h10, 32'hDEADBEEF, F3_W, 0, 32'h0, 0);
        do_req(0, 32'h10, 32'h0, F3_W, 0, 32'hDEADBEEF, 1);

        do_req(1, 32'h10, 32'h11223344, F3_W, 0, 32'h0, 0);
        do_req(1, 32'h11, 32'h000000A5, F3_B, 0, 32'h0, 0);
        do_req(0, 32'h11, 32'h0, F3_B,  0, 32'hFFFFFFA5, 1);
        do_req(0, 32'h11, 32'h0, F3_BU, 0, 32'h000000A5, 1);
        do_req(0, 32'h10, 32'h0, F3_W,  0, 32'h1122A544, 1);
        do_req(0, 32'h12, 32'h0, F3_H,  0, 32'h00001122, 1);
        do_req(0, 32'h10, 32'h0, F3_HU, 0, 32'h0000A544, 1);
        do_req(0, 32'h10, 32'h0, F3_H,  0, 32'hFFFFA544, 1);
        do_req(1, 32'h12, 32'h0000BEEF, F3_H, 0, 32'h0, 0);
        do_req(0, 32'h10, 32'h0, F3_W,  0, 32'hBEEFA544, 1);
        do_req(0, 32'h13, 32'h0, F3_B,  0, 32'hFFFFFFBE, 1);

        do_req(0, 32'h13, 32'h0, F3_H, 1, 32'h0, 1);
        do_req(1, 32'h20, 32'h55AA55AA, F3_W, 0, 32'h0, 0);
        do_req(1, 32'h22, 32'hFFFFFFFF, F3_W, 1, 32'h0, 0);
        do_req(1, 32'h21, 32'hFFFFFFFF, F3_H, 1, 32'h0, 0);
        do_req(1, 32'h20, 32'hFFFFFFFF, 3'b100, 1, 32'h0, 0);
        do_req(0, 32'h20, 32'h0, 3'b011, 1, 32'h0, 1);
        do_req(0, 32'h21, 32'h0, F3_W, 1, 32'h0, 1);
        do_req(0, 32'h20, 32'h0, F3_W, 0, 32'h55AA55AA, 1);

        do_req(1, 32'h30, 32'hAAAA0000, F3_W, 0, 32'h0, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h12345678; f3 = F3_W;
        @(negedge clk);
        reset = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", {31'd0, ready}, 32'd0);
        end
        do_req(0, 32'h30, 32'h0, F3_W, 0, 32'hAAAA0000, 1);

        do_req(1, 32'h400, 32'hCAFEF00D, F3_W, 0, 32'h0, 0);
        do_req(0, 32'h0, 32'h0, F3_W, 0, 32'hCAFEF00D, 1);
        do_req(0, 32'h402, 32'h0, F3_HU, 0, 32'h0000CAFE, 1);

        // LATENCY=1: req held high gives accept / RESP alternating.
        @(negedge clk);
        n = cyc;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h01020304; f31 = F3_W;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("lat1_ready", {31'd0, ready1}, {31'd0, (cyc - n) % 2 == 1});
        end
        we1 = 1'b0;
        @(negedge clk);
        check("lat1_ld_ready", {31'd0, ready1}, 32'd1);
        check("lat1_rdata", rdata1, 32'h01020304);
        req1 = 1'b0;

        // LATENCY=4: ready exactly 4 cycles after the drive cycle.
        @(negedge clk);
        n = cyc;
        req4 = 1'b1; we4 = 1'b1; addr4 = 32'h44; wdata4 = 32'h0BADCAFE; f34 = F3_W;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("lat4_st_ready", {31'd0, ready4}, {31'd0, cyc == n + 4});
            if (ready4) req4 = 1'b0;
        end
        n = cyc;
        req4 = 1'b1; we4 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("lat4_ld_ready", {31'd0, ready4}, {31'd0, cyc == n + 4});
            if (ready4) begin
                check("lat4_rdata", rdata4, 32'h0BADCAFE);
                req4 = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
